// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_share_arbiter.
// The slave modport is the arbiter's view and the master modport is the surrounding system's view.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             a_req_valid_i;
  logic             a_req_ready_o;
  logic [WIDTH-1:0] a_src1_i;
  logic [WIDTH-1:0] a_src2_i;
  logic [3:0]       a_ctrl_i;

  logic             b_req_valid_i;
  logic             b_req_ready_o;
  logic [WIDTH-1:0] b_src1_i;
  logic [WIDTH-1:0] b_src2_i;
  logic [3:0]       b_ctrl_i;

  logic             a_rsp_valid_o;
  logic             a_rsp_ready_i;
  logic             b_rsp_valid_o;
  logic             b_rsp_ready_i;
  logic [WIDTH-1:0] rsp_result_o;
  logic             rsp_zero_o;
  logic             rsp_err_o;

  logic [WIDTH-1:0] alu_src1_o;
  logic [WIDTH-1:0] alu_src2_o;
  logic [3:0]       alu_ctrl_o;
  logic [WIDTH-1:0] alu_result_i;
  logic             alu_zero_i;

  logic             busy_o;

  modport slave (
    input  a_req_valid_i, a_src1_i, a_src2_i, a_ctrl_i,
    input  b_req_valid_i, b_src1_i, b_src2_i, b_ctrl_i,
    input  a_rsp_ready_i, b_rsp_ready_i,
    input  alu_result_i, alu_zero_i,
    output a_req_ready_o, b_req_ready_o,
    output a_rsp_valid_o, b_rsp_valid_o,
    output rsp_result_o, rsp_zero_o, rsp_err_o,
    output alu_src1_o, alu_src2_o, alu_ctrl_o,
    output busy_o
  );

  modport master (
    output a_req_valid_i, a_src1_i, a_src2_i, a_ctrl_i,
    output b_req_valid_i, b_src1_i, b_src2_i, b_ctrl_i,
    output a_rsp_ready_i, b_rsp_ready_i,
    output alu_result_i, alu_zero_i,
    input  a_req_ready_o, b_req_ready_o,
    input  a_rsp_valid_o, b_rsp_valid_o,
    input  rsp_result_o, rsp_zero_o, rsp_err_o,
    input  alu_src1_o, alu_src2_o, alu_ctrl_o,
    input  busy_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between requesters A and B.
// Each operation takes IDLE (accept) -> EXEC (ALU evaluates) -> RESP (held response).
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_last_b;
  logic             r_owner_b;

  logic [WIDTH-1:0] r_src1_p0;
  logic [WIDTH-1:0] r_src2_p0;
  logic [3:0]       r_ctrl_p0;

  logic [WIDTH-1:0] r_result_p1;
  logic             r_zero_p1;
  logic             r_err_p1;

  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_accept;
  logic             w_rsp_done;
  logic             w_legal;

  function automatic logic ctrl_legal(input logic [3:0] ctrl);
    case (ctrl)
      4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] mask_result(input logic legal,
                                                   input logic [WIDTH-1:0] res);
    return legal ? res : '0;
  endfunction

  // Grant is gated by rst_i so no ready can be seen while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst_i) begin
          w_grant_a = bus.a_req_valid_i && (!bus.b_req_valid_i || r_last_b);
          w_grant_b = bus.b_req_valid_i && (!bus.a_req_valid_i || !r_last_b);
        end
        if (w_grant_a || w_grant_b) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = RESP;
      end
      RESP: begin
        w_rsp_done = r_owner_b ? bus.b_rsp_ready_i : bus.a_rsp_ready_i;
        if (w_rsp_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_accept = w_grant_a || w_grant_b;
  assign w_legal  = ctrl_legal(r_ctrl_p0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_last_b  <= 1'b1;
      r_owner_b <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_last_b  <= w_grant_b;
        r_owner_b <= w_grant_b;
      end
    end
  end

  // p0: operand capture on accept; held so the ALU inputs never follow request changes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_src1_p0 <= '0;
      r_src2_p0 <= '0;
      r_ctrl_p0 <= '0;
    end else if (w_accept) begin
      r_src1_p0 <= w_grant_b ? bus.b_src1_i : bus.a_src1_i;
      r_src2_p0 <= w_grant_b ? bus.b_src2_i : bus.a_src2_i;
      r_ctrl_p0 <= w_grant_b ? bus.b_ctrl_i : bus.a_ctrl_i;
    end
  end

  // p1: ALU result capture at the end of EXEC; unsupported codes report 0 / zero / err.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_result_p1 <= '0;
      r_zero_p1   <= 1'b0;
      r_err_p1    <= 1'b0;
    end else if (r_state == EXEC) begin
      r_result_p1 <= mask_result(w_legal, bus.alu_result_i);
      r_zero_p1   <= w_legal ? bus.alu_zero_i : 1'b1;
      r_err_p1    <= !w_legal;
    end
  end

  assign bus.a_req_ready_o = w_grant_a;
  assign bus.b_req_ready_o = w_grant_b;
  assign bus.a_rsp_valid_o = (r_state == RESP) && !r_owner_b;
  assign bus.b_rsp_valid_o = (r_state == RESP) && r_owner_b;
  assign bus.rsp_result_o  = r_result_p1;
  assign bus.rsp_zero_o    = r_zero_p1;
  assign bus.rsp_err_o     = r_err_p1;
  assign bus.alu_src1_o    = r_src1_p0;
  assign bus.alu_src2_o    = r_src2_p0;
  assign bus.alu_ctrl_o    = r_ctrl_p0;
  assign bus.busy_o        = (r_state != IDLE);

`ifndef SYNTHESIS
  a_one_grant: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.a_req_ready_o && bus.b_req_ready_o));

  a_rsp_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_state == RESP && !w_rsp_done) |=> ($stable(r_result_p1) && $stable(r_err_p1)));
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed-vector bench for alu_share_arbiter with a behavioural 32-bit ALU attached.
module tb_alu_share_arbiter;

  logic clk_i = 1'b0;
  logic rst_i;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter_if #(.WIDTH(32)) bus ();

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] w_alu_res;

  always_comb begin
    w_alu_res = 32'hDEAD_BEEF;
    case (bus.alu_ctrl_o)
      4'd0:  w_alu_res = bus.alu_src1_o & bus.alu_src2_o;
      4'd1:  w_alu_res = bus.alu_src1_o | bus.alu_src2_o;
      4'd2:  w_alu_res = bus.alu_src1_o + bus.alu_src2_o;
      4'd6:  w_alu_res = bus.alu_src1_o - bus.alu_src2_o;
      4'd7:  w_alu_res = ($signed(bus.alu_src1_o) < $signed(bus.alu_src2_o)) ? 32'd1 : 32'd0;
      4'd12: w_alu_res = ~(bus.alu_src1_o | bus.alu_src2_o);
      default: w_alu_res = 32'hDEAD_BEEF;
    endcase
  end

  assign bus.alu_result_i = w_alu_res;
  assign bus.alu_zero_i   = (w_alu_res == 32'd0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_op(input string tag, input bit use_b,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [3:0] c,
                       input logic [31:0] er, input logic ez, input logic ee);
    tick();
    if (use_b) begin
      bus.b_req_valid_i = 1'b1; bus.b_src1_i = s1; bus.b_src2_i = s2; bus.b_ctrl_i = c;
    end else begin
      bus.a_req_valid_i = 1'b1; bus.a_src1_i = s1; bus.a_src2_i = s2; bus.a_ctrl_i = c;
    end
    #1;
    chk({tag, "_rdy"}, use_b ? bus.b_req_ready_o : bus.a_req_ready_o, 32'd1);
    tick();
    bus.a_req_valid_i = 1'b0;
    bus.b_req_valid_i = 1'b0;
    #1;
    chk({tag, "_exec_busy"}, bus.busy_o, 32'd1);
    tick();
    #1;
    chk({tag, "_vld"},   use_b ? bus.b_rsp_valid_o : bus.a_rsp_valid_o, 32'd1);
    chk({tag, "_other"}, use_b ? bus.a_rsp_valid_o : bus.b_rsp_valid_o, 32'd0);
    chk({tag, "_res"},   bus.rsp_result_o, er);
    chk({tag, "_zero"},  bus.rsp_zero_o, {31'd0, ez});
    chk({tag, "_err"},   bus.rsp_err_o, {31'd0, ee});
    tick();
    #1;
    chk({tag, "_vld_drop"}, use_b ? bus.b_rsp_valid_o : bus.a_rsp_valid_o, 32'd0);
  endtask

  initial begin
    bus.a_req_valid_i = 1'b1;
    bus.a_src1_i = 32'd0; bus.a_src2_i = 32'd0; bus.a_ctrl_i = 4'd0;
    bus.b_req_valid_i = 1'b0;
    bus.b_src1_i = 32'd0; bus.b_src2_i = 32'd0; bus.b_ctrl_i = 4'd0;
    bus.a_rsp_ready_i = 1'b1;
    bus.b_rsp_ready_i = 1'b1;
    rst_i = 1'b1;

    // Reset values, with a request already pending on A.
    tick();
    tick();
    #1;
    chk("rst_a_rdy",  bus.a_req_ready_o, 32'd0);
    chk("rst_busy",   bus.busy_o, 32'd0);
    chk("rst_res",    bus.rsp_result_o, 32'd0);
    chk("rst_zero",   bus.rsp_zero_o, 32'd0);
    chk("rst_alu1",   bus.alu_src1_o, 32'd0);
    chk("rst_a_vld",  bus.a_rsp_valid_o, 32'd0);
    rst_i = 1'b0;
    bus.a_req_valid_i = 1'b0;

    // Single op: 5 - 3 = 2 on A.
    do_op("sub", 1'b0, 32'd5, 32'd3, 4'd6, 32'd2, 1'b0, 1'b0);
    // B op so that last grant is B before contention.
    do_op("addb", 1'b1, 32'd10, 32'd20, 4'd2, 32'd30, 1'b0, 1'b0);

    // Contention: A (7 AND 3 = 3) and B (0xF0 OR 0x0F = 0xFF) both held valid.
    tick();
    bus.a_req_valid_i = 1'b1; bus.a_src1_i = 32'd7;    bus.a_src2_i = 32'd3;    bus.a_ctrl_i = 4'd0;
    bus.b_req_valid_i = 1'b1; bus.b_src1_i = 32'hF0; bus.b_src2_i = 32'h0F; bus.b_ctrl_i = 4'd1;
    for (int i = 0; i < 12; i++) begin
      if (i != 0) tick();
      #1;
      chk($sformatf("rr_a_rdy%0d", i), bus.a_req_ready_o, (i % 6 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("rr_b_rdy%0d", i), bus.b_req_ready_o, (i % 6 == 3) ? 32'd1 : 32'd0);
      if (i % 6 == 2) chk($sformatf("rr_a_res%0d", i), bus.a_rsp_valid_o ? bus.rsp_result_o : 32'hFFFF_FFFF, 32'd3);
      if (i % 6 == 5) chk($sformatf("rr_b_res%0d", i), bus.b_rsp_valid_o ? bus.rsp_result_o : 32'hFFFF_FFFF, 32'hFF);
    end
    tick();
    bus.a_req_valid_i = 1'b0;
    bus.b_req_valid_i = 1'b0;

    // Backpressure: B adds 0xFFFFFFFF + 1 while A waits.
    tick();
    bus.b_req_valid_i = 1'b1; bus.b_src1_i = 32'hFFFF_FFFF; bus.b_src2_i = 32'd1; bus.b_ctrl_i = 4'd2;
    bus.b_rsp_ready_i = 1'b0;
    #1;
    chk("bp_b_rdy", bus.b_req_ready_o, 32'd1);
    tick();
    bus.b_req_valid_i = 1'b0;
    bus.a_req_valid_i = 1'b1; bus.a_src1_i = 32'd1; bus.a_src2_i = 32'd1; bus.a_ctrl_i = 4'd2;
    #1;
    chk("bp_a_rdy_exec", bus.a_req_ready_o, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk($sformatf("bp_b_vld%0d", k), bus.b_rsp_valid_o, 32'd1);
      chk($sformatf("bp_res%0d", k),   bus.rsp_result_o, 32'd0);
      chk($sformatf("bp_zero%0d", k),  bus.rsp_zero_o, 32'd1);
      chk($sformatf("bp_a_rdy%0d", k), bus.a_req_ready_o, 32'd0);
    end
    tick();
    bus.b_rsp_ready_i = 1'b1;
    #1;
    chk("bp_b_vld_last", bus.b_rsp_valid_o, 32'd1);
    chk("bp_a_rdy_last", bus.a_req_ready_o, 32'd0);
    tick();
    #1;
    chk("bp_b_vld_drop", bus.b_rsp_valid_o, 32'd0);
    chk("bp_a_accept",   bus.a_req_ready_o, 32'd1);
    tick();
    bus.a_req_valid_i = 1'b0;
    tick();
    #1;
    chk("bp_a_vld", bus.a_rsp_valid_o, 32'd1);
    chk("bp_a_res", bus.rsp_result_o, 32'd2);
    tick();

    // SLT, NOR, illegal code, then a legal op clears err.
    do_op("slt", 1'b0, 32'd2, 32'd9, 4'd7, 32'd1, 1'b0, 1'b0);
    do_op("nor", 1'b0, 32'd0, 32'd0, 4'd12, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("ill", 1'b0, 32'd0, 32'd0, 4'd4, 32'd0, 1'b1, 1'b1);
    do_op("and", 1'b0, 32'hF0F0, 32'h0FF0, 4'd0, 32'h00F0, 1'b0, 1'b0);

    // Reset while A's response is pending.
    tick();
    bus.a_req_valid_i = 1'b1; bus.a_src1_i = 32'd4; bus.a_src2_i = 32'd5; bus.a_ctrl_i = 4'd0;
    bus.a_rsp_ready_i = 1'b0;
    #1;
    chk("rr_pre_rdy", bus.a_req_ready_o, 32'd1);
    tick();
    bus.a_req_valid_i = 1'b0;
    tick();
    #1;
    chk("mid_a_vld", bus.a_rsp_valid_o, 32'd1);
    chk("mid_res",   bus.rsp_result_o, 32'd4);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_vld",  bus.a_rsp_valid_o, 32'd0);
    chk("mid_rst_busy", bus.busy_o, 32'd0);
    chk("mid_rst_res",  bus.rsp_result_o, 32'd0);
    chk("mid_rst_alu1", bus.alu_src1_o, 32'd0);
    tick();
    rst_i = 1'b0;
    bus.a_rsp_ready_i = 1'b1;
    #1;
    chk("post_rst_vld", bus.a_rsp_valid_o, 32'd0);
    tick();
    bus.a_req_valid_i = 1'b1; bus.a_src1_i = 32'd1; bus.a_src2_i = 32'd2; bus.a_ctrl_i = 4'd2;
    bus.b_req_valid_i = 1'b1; bus.b_src1_i = 32'd8; bus.b_src2_i = 32'd8; bus.b_ctrl_i = 4'd2;
    #1;
    chk("post_rst_a_rdy", bus.a_req_ready_o, 32'd1);
    chk("post_rst_b_rdy", bus.b_req_ready_o, 32'd0);
    tick();
    bus.a_req_valid_i = 1'b0;
    bus.b_req_valid_i = 1'b0;
    tick();
    #1;
    chk("post_rst_a_vld", bus.a_rsp_valid_o, 32'd1);
    chk("post_rst_res",   bus.rsp_result_o, 32'd3);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

- Shares one 32-bit combinational ALU between two requesters, A and B. Each requester issues operations through a valid/ready handshake.
- Grants use round-robin. The block registers the winner's operands and control code, drives them to the ALU and captures the ALU's result and zero flag. It then returns them to the winning requester through a held response handshake.
- It sits between the ALU and the units that need it (e.g. decode-side address calculation and a multi-cycle helper), and it is the only driver of the ALU's inputs.

## Interface
- WIDTH, 32, operand/result width; must match ALU data width.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- a_req_valid_i  in  1  requester A has an operation.
- a_req_ready_o  out  1  A's operation accepted this cycle.
- a_src1_i, a_src2_i  in  WIDTH  A's operands.
- a_ctrl_i  in  4  A's ALU control code.
- b_req_valid_i, b_req_ready_o, b_src1_i, b_src2_i, b_ctrl_i: identical to A, for requester B.
- a_rsp_valid_o  out  1  response for A is on the shared response bus.
- a_rsp_ready_i  in  1  A consumes its response.
- b_rsp_valid_o  out  1  response for B is on the shared response bus.
- b_rsp_ready_i  in  1  B consumes its response.
- rsp_result_o  out  WIDTH  captured ALU result.
- rsp_zero_o  out  1  captured ALU zero flag.
- rsp_err_o  out  1  operation used an unsupported control code.
- alu_src1_o, alu_src2_o  out  WIDTH  to ALU operands.
- alu_ctrl_o  out  4  to ALU control.
- alu_result_i  in  WIDTH  from ALU result.
- alu_zero_i  in  1  from ALU zero flag.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- Supported control codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR. Any other code is unsupported.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Arbitrate among the asserted req_valid inputs.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins. The last-grant pointer resets to B, so A wins the first contention.
  - The winner's req_ready is high combinationally in the same cycle; the loser's req_ready is low.
  - On the handshake: latch src1, src2 and ctrl into operand registers, record the owner (A or B), update the last-grant pointer, and go to EXEC.
- EXEC (one cycle):
  - alu_*_o are driven from the operand registers.
  - At the end of the cycle, capture alu_result_i and alu_zero_i into the response registers.
  - If ctrl is unsupported: force the captured result to 0, zero to 1 and err to 1. Otherwise err is 0.
  - Go to RESP.
- RESP:
  - Only the owner's rsp_valid is high. rsp_result_o, rsp_zero_o and rsp_err_o hold stable.
  - When the owner's rsp_ready is high, go to IDLE. The non-owner's rsp_ready is ignored.
- alu_src1_o, alu_src2_o and alu_ctrl_o are always driven from the operand registers. They keep their last value outside EXEC and never glitch on request changes.
- Requests that arrive during EXEC or RESP see req_ready low and must stay asserted until accepted. A valid request is never dropped.

## Timing
- Reset values: operand registers 0, alu_*_o 0, rsp_result_o 0, rsp_zero_o 0, rsp_err_o 0, all req_ready 0, all rsp_valid 0, busy_o 0, state IDLE, last-grant B.
- Latency: accept in cycle N, EXEC in N+1, rsp_valid high from N+2.
- Throughput: with rsp_ready held high, back-to-back operations are accepted every 3 cycles (N, N+3, N+6...).
- rsp_valid falls in the cycle after the handshake. A new accept can occur in that same IDLE cycle.
- rst_i asserted mid-operation (EXEC or RESP): the state goes to IDLE immediately and all outputs take their reset values. The in-flight result is discarded and no response is produced.
- Simultaneous valid from A and B in IDLE: exactly one ready is asserted, as selected by the round-robin rule above.

## Test plan
- Single op: A issues src1=5, src2=3, ctrl=6. Required: a_req_ready=1 in the issue cycle; a_rsp_valid=1 two cycles later with result=2, zero=0, err=0; b_rsp_valid=0 throughout.
- Contention fairness: A and B both hold valid continuously, with rsp_ready always 1. Required grant order A, B, A, B; accepts are spaced 3 cycles apart.
- Backpressure: B issues ADD 0xFFFFFFFF+1 with b_rsp_ready=0 for 5 cycles. Required: result=0 and zero=1, held stable; b_rsp_valid stays high; a_req_ready stays 0 for a pending A request until B consumes.
- SLT and NOR: A issues src1=2, src2=9, ctrl=7, then src1=0, src2=0, ctrl=12. Required results 1 and 0xFFFFFFFF, each with zero=0.
- Illegal code: A issues ctrl=4. Required: result=0, zero=1, err=1; the next legal op returns err=0.
- Reset in RESP: assert rst_i while a_rsp_valid=1. Required: a_rsp_valid drops immediately, busy_o=0, and the next contention grants A first.
